multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for KGP-RISC: steps fetch/decode/execute/memory/writeback per instruction.
//  Drives PC, IR and regfile enables and the shared single-port memory handshake.
//  Sits between opcode decode (IR[31:26]) and the datapath; the per-op ALU control stays in main_control.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles mem_req may wait for mem_ready before entering ERR (1..255)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst           in   1  asynchronous, active-high reset
//  opcode        in   6  IR[31:26], valid from ID onward
//  branch_taken  in   1  branch condition from branch unit, sampled in EX
//  mem_ready     in   1  memory completed the current request this cycle
//  halt_req      in   1  request stop at the next instruction boundary
//  mem_req       out  1  memory request, held until mem_ready
//  mem_we        out  1  write strobe, qualifies mem_req (SW only)
//  ir_write      out  1  load IR from memory read data
//  pc_write      out  1  update PC
//  pc_src        out  1  0 = PC+4, 1 = branch/jump target
//  reg_write     out  1  regfile write enable
//  wb_sel        out  2  00 ALU result, 01 mem data, 10 PC+4
//  instr_done    out  1  one-cycle pulse on instruction retire
//  state         out  3  IDLE=0 IF=1 ID=2 EX=3 MEM=4 WB=5 HALT=6 ERR=7
//  halted        out  1  high in HALT or ERR
//  mem_err       out  1  high in ERR only
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0, all outputs 0. Reset asserted mid-transaction aborts it at once.
//  - Opcode classes: ALU 000000-000011; LW 000100; SW 000101; JAL 000110; BR 1111xx; else illegal.
//  - IDLE: always -> IF on the next clk.
//  - IF: mem_req=1, mem_we=0. mem_ready=1 -> ir_write=1 same cycle, -> ID.
//  - ID: 1 cycle; class latched from opcode; -> EX. Illegal opcode: see CONFIGURATION.
//  - EX: 1 cycle. BR: pc_write=1, pc_src=branch_taken, instr_done=1, -> IF.
//        ALU/JAL -> WB; LW/SW -> MEM.
//  - MEM: mem_req=1, mem_we=(SW). mem_ready=1: LW -> WB;
//        SW -> pc_write=1, pc_src=0, instr_done=1, -> IF.
//  - WB: reg_write=1; wb_sel=00 ALU, 01 LW, 10 JAL.
//        pc_write=1, pc_src=(JAL), instr_done=1, -> IF.
//  - Outputs are Moore-decoded from state; ir_write and the MEM/SW retire signals are also qualified by mem_ready.
//  - mem_ready is ignored outside IF/MEM. mem_req is never dropped before mem_ready.
//  - Wait counter: clears on entering IF/MEM; +1 per cycle with mem_req=1 and mem_ready=0.
//    Reaching MEM_TIMEOUT -> ERR; counter saturates.
//    mem_ready on the same cycle the count is reached wins (no ERR).
//  - Latency without waits: BR 3 cyc; ALU/JAL 4; SW 4; LW 5. Each wait cycle adds 1.
//  - halt_req sampled only in a cycle with instr_done=1; if set, -> HALT instead of IF.
//  - HALT/ERR: terminal, all enables 0, exit only via rst.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode in ID -> ERR next cycle (mem_err=1), no retire.
//  ILLEGAL_TRAP_EN undefined: illegal opcode treated as NOP: ID -> EX -> pc_write=1, pc_src=0,
//    instr_done=1, -> IF (3 cycles, no reg/mem write).
// TESTING
//  1. rst pulse mid-MEM with mem_req=1 -> all outputs 0 at once; state IDLE, then IF 1 cycle after release.
//  2. ALU op 000001, mem_ready=1 in IF -> IF,ID,EX,WB, then IF.
//     reg_write=1, wb_sel=00, instr_done pulse on cycle 4.
//  3. LW 000100, mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0;
//     then WB with wb_sel=01; total 8 cycles.
//  4. SW 000101 -> mem_we=1 with mem_req in MEM; reg_write stays 0.
//     BR 111100 with branch_taken=1 -> pc_src=1 in EX.
//  5. mem_ready held 0 in IF, MEM_TIMEOUT=15 -> ERR after 15 cycles, mem_err=1, halted=1;
//     repeat with ready on cycle 15 -> ID.
//  6. Opcode 010000: TRAP_EN -> ERR after ID; without -> retires with pc_src=0.
//     halt_req=1 at retire -> HALT.

Source files
------------

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: sequencer control bus between the KGP-RISC datapath, decode and the shared memory.
// master (sequencer): in  opcode[5:0], branch_taken, mem_ready, halt_req
//                     out mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel[1:0],
//                         instr_done, state[2:0], halted, mem_err
// slave (datapath/memory side): the same signals with the opposite directions
interface multicycle_sequencer_if;
    logic [5:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       halt_req;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_done;
    logic [2:0] state;
    logic       halted;
    logic       mem_err;
    modport master (
        input  opcode, branch_taken, mem_ready, halt_req,
        output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel,
               instr_done, state, halted, mem_err
    );
    modport slave (
        output opcode, branch_taken, mem_ready, halt_req,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel,
               instr_done, state, halted, mem_err
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: KGP-RISC multi-cycle IF/ID/EX/MEM/WB control FSM with memory wait timeout.
// Ports: clk, rst (async, active-high); bus = multicycle_sequencer_if.master
//   (opcode, branch_taken, mem_ready, halt_req in; memory handshake, PC/IR/regfile enables,
//    wb_sel, instr_done, state, halted, mem_err out).
// Parameter MEM_TIMEOUT: cycles a memory request may wait before the FSM enters ERR (1..255).
// Macro ILLEGAL_TRAP_EN: when defined an illegal opcode traps to ERR from ID; otherwise it retires as a NOP.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2, ST_EX = 3'd3,
        ST_MEM  = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_ERR = 3'd7
    } state_t;
    typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_JAL, C_BR, C_ILL} cls_t;
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
    state_t     state, state_nxt;
    cls_t       cls, dec;
    logic [7:0] wait_cnt;
    logic       mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, instr_done;
    logic [1:0] wb_sel;
    logic       timeout;
    assign dec = bus.opcode[5:2] == 4'b1111 ? C_BR  :
                 bus.opcode[5:2] == 4'b0000 ? C_ALU :
                 bus.opcode == 6'b000100    ? C_LW  :
                 bus.opcode == 6'b000101    ? C_SW  :
                 bus.opcode == 6'b000110    ? C_JAL : C_ILL;
    // The wait that would bring the count to MEM_TIMEOUT is the last one allowed.
    assign timeout = wait_cnt >= TMO - 8'd1;
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        instr_done = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_IF;
            ST_IF: begin
                mem_req   = 1'b1;
                ir_write  = bus.mem_ready;
                state_nxt = bus.mem_ready ? ST_ID : timeout ? ST_ERR : ST_IF;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_ID: state_nxt = dec == C_ILL ? ST_ERR : ST_EX;
`else
            ST_ID: state_nxt = ST_EX;
`endif
            ST_EX: begin
                // BR and NOP-treated illegal ops retire here; LW/SW go to memory.
                pc_write   = cls == C_BR || cls == C_ILL;
                pc_src     = cls == C_BR && bus.branch_taken;
                instr_done = pc_write;
                state_nxt  = pc_write ? ST_IF : (cls == C_LW || cls == C_SW) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_req    = 1'b1;
                mem_we     = cls == C_SW;
                pc_write   = mem_we && bus.mem_ready;
                instr_done = pc_write;
                state_nxt  = bus.mem_ready ? (mem_we ? ST_IF : ST_WB) : timeout ? ST_ERR : ST_MEM;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel     = cls == C_LW ? 2'b01 : cls == C_JAL ? 2'b10 : 2'b00;
                pc_write   = 1'b1;
                pc_src     = cls == C_JAL;
                instr_done = 1'b1;
                state_nxt  = ST_IF;
            end
            default: state_nxt = state;
        endcase
        // halt_req only matters at an instruction boundary.
        if (instr_done && bus.halt_req) state_nxt = ST_HALT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cls      <= C_ALU;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_ID) cls <= dec;
            if ((state_nxt == ST_IF || state_nxt == ST_MEM) && state_nxt != state)
                wait_cnt <= 8'd0;
            else if (mem_req && !bus.mem_ready && wait_cnt != TMO)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.reg_write  = reg_write;
    assign bus.wb_sel     = wb_sel;
    assign bus.instr_done = instr_done;
    assign bus.state      = state;
    assign bus.halted     = state == ST_HALT || state == ST_ERR;
    assign bus.mem_err    = state == ST_ERR;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer (MEM_TIMEOUT=15).
module tb_multicycle_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    multicycle_sequencer_if bus();
    multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // {state, mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, wb_sel, instr_done, halted, mem_err}
    function automatic logic [14:0] pk(input logic [2:0] s, input logic rq, we, irw, pcw, src, rw,
                                       input logic [1:0] wb, input logic dn, hl, er);
        return {s, rq, we, irw, pcw, src, rw, wb, dn, hl, er};
    endfunction
    function automatic logic [14:0] obs();
        return pk(bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_src,
                  bus.reg_write, bus.wb_sel, bus.instr_done, bus.halted, bus.mem_err);
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    // Inputs are set before the call; outputs are checked, then one clock edge passes.
    task automatic cyc(input string tag, input logic [14:0] e);
        #1;
        check(tag, {17'd0, obs()}, {17'd0, e});
        @(posedge clk);
        #1;
    endtask
    task automatic fetch(input logic [5:0] op);
        bus.opcode = op;
        bus.mem_ready = 1'b1;
        cyc("fetch", pk(3'd1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.mem_ready = 1'b0;
        cyc("decode", pk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async", {17'd0, obs()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rst_idle", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    endtask
    initial begin
        bus.opcode = 6'd0;
        bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b0;
        bus.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {17'd0, obs()}, 32'd0);
        rst = 1'b0;
        cyc("idle", pk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        fetch(6'b000001);
        cyc("alu_ex", pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        cyc("alu_wb", pk(3'd5, 0, 0, 0, 1, 0, 1, 2'b00, 1, 0, 0));
        fetch(6'b000100);
        cyc("lw_ex", pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", pk(3'd4, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("lw_mem_done", pk(3'd4, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.mem_ready = 1'b0;
        cyc("lw_wb", pk(3'd5, 0, 0, 0, 1, 0, 1, 2'b01, 1, 0, 0));
        bus.halt_req = 1'b1;
        fetch(6'b000101);
        cyc("sw_ex", pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.halt_req = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("sw_mem", pk(3'd4, 1, 1, 0, 1, 0, 0, 2'b00, 1, 0, 0));
        fetch(6'b111100);
        bus.branch_taken = 1'b1;
        cyc("br_taken_ex", pk(3'd3, 0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 0));
        fetch(6'b111111);
        bus.branch_taken = 1'b0;
        cyc("br_not_taken_ex", pk(3'd3, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0));
        fetch(6'b000110);
        bus.branch_taken = 1'b1;
        cyc("jal_ex", pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        cyc("jal_wb", pk(3'd5, 0, 0, 0, 1, 1, 1, 2'b10, 1, 0, 0));
        bus.branch_taken = 1'b0;
        fetch(6'b010000);
`ifdef ILLEGAL_TRAP_EN
        cyc("ill_trap", pk(3'd7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
        bus.mem_ready = 1'b1;
        cyc("ill_trap_hold", pk(3'd7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
`else
        bus.halt_req = 1'b1;
        cyc("ill_nop_ex", pk(3'd3, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0, 0));
        bus.halt_req = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("halt", pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
        cyc("halt_hold", pk(3'd6, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
`endif
        do_reset();
        fetch(6'b000100);
        cyc("rst_lw_ex", pk(3'd3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        cyc("rst_lw_mem", pk(3'd4, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        do_reset();
        for (int i = 1; i <= 15; i++) cyc("to_if_wait", pk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("to_err", pk(3'd7, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1));
        bus.mem_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 14; i++) cyc("late_if_wait", pk(3'd1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.mem_ready = 1'b1;
        cyc("late_if_ready", pk(3'd1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
        bus.mem_ready = 1'b0;
        cyc("late_id", pk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
